// File: rtl/jk_bank_arbiter.sv
// Bank of N_FF JK flip-flops with a two-requester round-robin arbiter and an optional lock.
// One granted {j,k} op per cycle is applied to the addressed flop; out-of-range indices raise err.
module jk_bank_arbiter #(
  parameter int N_FF  = 8,
  parameter int IDX_W = 3
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             req0_valid,
  input  logic [IDX_W-1:0] req0_idx,
  input  logic [1:0]       req0_jk,
  input  logic             req0_lock,
  output logic             req0_ready,
  input  logic             req1_valid,
  input  logic [IDX_W-1:0] req1_idx,
  input  logic [1:0]       req1_jk,
  input  logic             req1_lock,
  output logic             req1_ready,
  output logic [N_FF-1:0]  q,
  output logic             err,
  output logic [1:0]       owner
);

  // State encoding doubles as the owner code, so owner comes straight from a register.
  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    LOCK0 = 2'b01,
    LOCK1 = 2'b10
  } state_t;

  localparam logic [IDX_W:0] LIMIT = (IDX_W + 1)'(N_FF);

  state_t            r_state;
  logic              r_prio;
  logic [N_FF-1:0]   r_q;
  logic              r_err;

  logic              w_ready0;
  logic              w_ready1;
  logic              w_xfer0;
  logic              w_xfer1;
  logic              w_xfer;
  logic [IDX_W-1:0]  w_idx;
  logic [1:0]        w_jk;
  logic              w_lock;
  logic              w_inRange;
  logic [N_FF-1:0]   w_qNext;

  always_comb begin
    w_ready0 = 1'b0;
    w_ready1 = 1'b0;
    case (r_state)
      IDLE: begin
        w_ready0 = req0_valid && (!req1_valid || !r_prio);
        w_ready1 = req1_valid && (!req0_valid ||  r_prio);
      end
      LOCK0:   w_ready0 = req0_valid;
      LOCK1:   w_ready1 = req1_valid;
      default: ;
    endcase
  end

  assign w_xfer0   = req0_valid && w_ready0;
  assign w_xfer1   = req1_valid && w_ready1;
  assign w_xfer    = w_xfer0 || w_xfer1;
  assign w_idx     = w_xfer1 ? req1_idx  : req0_idx;
  assign w_jk      = w_xfer1 ? req1_jk   : req0_jk;
  assign w_lock    = w_xfer1 ? req1_lock : req0_lock;
  assign w_inRange = ({1'b0, w_idx} < LIMIT);

  // Only the addressed flop can change; an out-of-range index matches no flop.
  always_comb begin
    w_qNext = r_q;
    for (int i = 0; i < N_FF; i++) begin
      if (w_xfer && w_inRange && (w_idx == IDX_W'(i))) begin
        case (w_jk)
          2'b01:   w_qNext[i] = 1'b0;
          2'b10:   w_qNext[i] = 1'b1;
          2'b11:   w_qNext[i] = ~r_q[i];
          default: w_qNext[i] = r_q[i];
        endcase
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= IDLE;
      r_prio  <= 1'b0;
    end else if (w_xfer0) begin
      r_state <= req0_lock ? LOCK0 : IDLE;
      if (!req0_lock) r_prio <= 1'b1;
    end else if (w_xfer1) begin
      r_state <= req1_lock ? LOCK1 : IDLE;
      if (!req1_lock) r_prio <= 1'b0;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_q   <= '0;
      r_err <= 1'b0;
    end else begin
      r_q   <= w_qNext;
      r_err <= w_xfer && !w_inRange;
    end
  end

  // w_lock is folded into the state update above per requester; keep it observable for clarity.
  logic w_unusedLock;
  assign w_unusedLock = w_lock;

  assign req0_ready = w_ready0;
  assign req1_ready = w_ready1;
  assign q          = r_q;
  assign err        = r_err;
  assign owner      = r_state;

endmodule
